// File: rtl/ica_dca_bus_responder.sv
// rtl/ica_dca_bus_responder.sv - burst-read responder for the ICA/DCA instruction-fetch bus
// One fetch request becomes one fixed-length memory burst, returned word by word on din.
module ica_dca_bus_responder #(
   parameter int BURST_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [21:0] address,
   input  logic        as,
   output logic [15:0] din,
   output logic        burstdata_valid,
   output logic        bus_ack,
   output logic        mem_req,
   output logic [20:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

   localparam logic [2:0] LAST_WORD = 3'(BURST_WORDS - 1);

   state_t      state, state_n;
   logic [2:0]  word_cnt, word_cnt_n;
   logic [15:0] din_n;
   logic        valid_n, ack_n, req_n;
   logic [20:0] addr_n;
   logic        last_word;

   assign last_word = (word_cnt == LAST_WORD);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         word_cnt        <= 3'd0;
         din             <= 16'd0;
         burstdata_valid <= 1'b0;
         bus_ack         <= 1'b0;
         mem_req         <= 1'b0;
         mem_addr        <= 21'd0;
      end else begin
         state           <= state_n;
         word_cnt        <= word_cnt_n;
         din             <= din_n;
         burstdata_valid <= valid_n;
         bus_ack         <= ack_n;
         mem_req         <= req_n;
         mem_addr        <= addr_n;
      end
   end

   always_comb begin
      state_n    = state;
      word_cnt_n = word_cnt;
      din_n      = din;
      valid_n    = 1'b0;
      ack_n      = 1'b0;
      req_n      = mem_req;
      addr_n     = mem_addr;
      case (state)
         // The ack cycle is skipped: as/address still belong to the finished burst then.
         IDLE: begin
            if (as && !bus_ack) begin
               addr_n  = address[21:1];
               req_n   = 1'b1;
               state_n = REQ;
            end
         end
         REQ: begin
            if (mem_gnt) begin
               req_n      = 1'b0;
               word_cnt_n = 3'd0;
               state_n    = as ? DATA : DRAIN;
            end else if (!as) begin
               req_n   = 1'b0;
               state_n = IDLE;
            end
         end
         DATA: begin
            if (mem_rvalid) begin
               word_cnt_n = last_word ? 3'd0 : word_cnt + 3'd1;
               if (as) begin
                  din_n   = mem_rdata;
                  valid_n = 1'b1;
                  ack_n   = last_word;
               end
               if (last_word)
                  state_n = IDLE;
               else if (!as)
                  state_n = DRAIN;
            end else if (!as) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (mem_rvalid) begin
               word_cnt_n = last_word ? 3'd0 : word_cnt + 3'd1;
               if (last_word)
                  state_n = IDLE;
            end
         end
      endcase
   end

   a_addr_aligned: assert property (@(posedge clk) disable iff (!reset)
      (state == IDLE && as) |-> !address[0]);
   a_rvalid_in_burst: assert property (@(posedge clk) disable iff (!reset)
      mem_rvalid |-> (state == DATA || state == DRAIN));
   a_gnt_with_req: assert property (@(posedge clk) disable iff (!reset)
      mem_gnt |-> mem_req);

endmodule
